// File: rtl/pulse_code_decoder.sv
// pulse_code_decoder
//   Samples a serial pulse line and decodes each high pulse into a symbol.
//   Pulses of at most DOT_MAX time units are symbol 0. Longer pulses are
//   symbol 1. A low gap of GAP_UNITS ends a code word, which is then written
//   to the code memory. A low gap of END_UNITS, or a full memory, ends the
//   message.
//
//   Optional build macro PULSE_GLITCH_FILTER_EN adds a glitch filter. With
//   it, a new level on the synchronised line is accepted only after FILT_CLKS
//   consecutive samples at that level.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-low
//   start     begin capture (ignored while busy)
//   sig_in    asynchronous pulse line
//   wr_en     one-cycle write strobe into the code memory
//   wr_addr   write address (holds its value between writes)
//   wr_data   {symbol count, code bits}, valid while wr_en=1
//   busy      capture in progress
//   done_fin  message complete (level)
//   err       sticky: a word carried more than CODE_W symbols
module pulse_code_decoder #(
  parameter int CODE_W    = 8,
  parameter int LEN_W     = 4,
  parameter int ADDR_W    = 5,
  parameter int TICK_DIV  = 1000,
  parameter int DOT_MAX   = 2,
  parameter int GAP_UNITS = 3,
  parameter int END_UNITS = 7,
  parameter int FILT_CLKS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sig_in,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LEN_W+CODE_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done_fin,
  output logic                    err
);

  localparam int         TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] UNIT_MAX = 4'd15;

  if ((2 ** LEN_W) <= CODE_W) begin : g_bad_len_w
    $error("LEN_W too small to count CODE_W symbols");
  end
  if (END_UNITS <= GAP_UNITS) begin : g_bad_end_units
    $error("END_UNITS must exceed GAP_UNITS");
  end
  if (FILT_CLKS < 1) begin : g_bad_filt_clks
    $error("FILT_CLKS must be at least 1");
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] u);
    return (u == UNIT_MAX) ? u : u + 4'd1;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HIGH,
    LOW,
    STORE,
    GAP,
    FIN
  } state_t;

  state_t              state;
  logic                sig_p0;
  logic                sig_p1;
  logic                lvl;
  logic                lvl_p2;
  logic                rise;
  logic                fall;
  logic [TICK_W-1:0]   tick;
  logic [3:0]          units;
  logic                tick_wrap;
  logic [3:0]          units_eff;
  logic                sym;
  logic [ADDR_W-1:0]   addr;
  logic [CODE_W-1:0]   code;
  logic [LEN_W-1:0]    len;

  // ---- stage p0/p1: two-flop synchroniser ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_p0 <= 1'b0;
      sig_p1 <= 1'b0;
    end else begin
      sig_p0 <= sig_in;
      sig_p1 <= sig_p0;
    end
  end

`ifdef PULSE_GLITCH_FILTER_EN
  localparam int FILT_W = $clog2(FILT_CLKS + 1);
  logic [FILT_W-1:0] filt_cnt;
  logic              filt_lvl;

  // ---- filter stage: the accepted level follows only a stable input ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sig_p1 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_W'(FILT_CLKS - 1)) begin
      filt_lvl <= sig_p1;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sig_p1;
`endif

  // ---- stage p2: edge detection ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_p2 <= 1'b0;
    else      lvl_p2 <= lvl;
  end

  assign rise = lvl & ~lvl_p2;
  assign fall = ~lvl & lvl_p2;

  // units_eff includes a wrap landing on this cycle. A pulse of N*TICK_DIV
  // clocks therefore measures exactly N units when its closing edge arrives.
  assign tick_wrap = (tick == TICK_W'(TICK_DIV - 1));
  assign units_eff = tick_wrap ? sat_inc(units) : units;
  assign sym       = (units_eff > 4'(DOT_MAX));

  // ---- timing: tick and unit counters, restarted on every edge ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick  <= '0;
      units <= '0;
    end else if (rise | fall) begin
      tick  <= '0;
      units <= '0;
    end else if (tick_wrap) begin
      tick  <= '0;
      units <= units_eff;
    end else begin
      tick  <= tick + TICK_W'(1);
    end
  end

  // ---- control: capture state machine with registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      code     <= '0;
      len      <= '0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done_fin <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            addr     <= '0;
            code     <= '0;
            len      <= '0;
            err      <= 1'b0;
            done_fin <= 1'b0;
            busy     <= 1'b1;
            state    <= ARM;
          end
        end
        ARM: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            if (len < LEN_W'(CODE_W)) begin
              code <= {code[CODE_W-2:0], sym};
              len  <= len + LEN_W'(1);
            end else begin
              err  <= 1'b1;
            end
            state <= LOW;
          end
        end
        LOW: begin
          // A new pulse arriving on the threshold cycle keeps the word open.
          if (rise) begin
            state <= HIGH;
          end else if (units_eff >= 4'(GAP_UNITS)) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= {len, code};
            state   <= STORE;
          end
        end
        STORE: begin
          code <= '0;
          len  <= '0;
          if (addr == {ADDR_W{1'b1}}) begin
            busy     <= 1'b0;
            done_fin <= 1'b1;
            state    <= FIN;
          end else begin
            addr  <= addr + ADDR_W'(1);
            // A pulse starting right on the store cycle opens the next word.
            state <= rise ? HIGH : GAP;
          end
        end
        GAP: begin
          if (rise) begin
            state <= HIGH;
          end else if (units_eff >= 4'(END_UNITS)) begin
            busy     <= 1'b0;
            done_fin <= 1'b1;
            state    <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_code_decoder.sv
module tb_pulse_code_decoder;
  localparam int T      = 4;
  localparam int CODE_W = 8;
  localparam int DOTM   = 2;
  localparam int GAPU   = 3;
  localparam int ENDU   = 7;
  localparam int DW     = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, sig = 1'b0, start2 = 1'b0, sig2 = 1'b0;
  logic          wr_en, busy, done_fin, err;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en2, busy2, done2, err2;
  logic [1:0]    wr_addr2;
  logic [DW-1:0] wr_data2;

  pulse_code_decoder #(.CODE_W(8), .LEN_W(4), .ADDR_W(5), .TICK_DIV(T), .DOT_MAX(DOTM),
                       .GAP_UNITS(GAPU), .END_UNITS(ENDU), .FILT_CLKS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sig_in(sig), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done_fin(done_fin), .err(err));

  pulse_code_decoder #(.CODE_W(8), .LEN_W(4), .ADDR_W(2), .TICK_DIV(T), .DOT_MAX(DOTM),
                       .GAP_UNITS(GAPU), .END_UNITS(ENDU), .FILT_CLKS(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sig_in(sig2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .busy(busy2), .done_fin(done2), .err(err2));

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t q1[$];
  wr_t q2[$];
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (wr_en)  q1.push_back('{addr: wr_addr, data: wr_data});
    if (wr_en2) q2.push_back('{addr: {3'b000, wr_addr2}, data: wr_data2});
  end

  int total = 0;
  int bad   = 0;
  int base;
  int hw[$];
  int lw[$];

  typedef struct { int width; int exp; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic l, input int n);
    sig = l;
    cyc(n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic chk_wr(input string nm, input int idx, input int a, input int d);
    if (idx < q1.size()) begin
      chk({nm, "_addr"}, int'(q1[idx].addr), a);
      chk({nm, "_data"}, int'(q1[idx].data), d);
    end else begin
      chk({nm, "_present"}, q1.size(), idx + 1);
    end
  endtask

  // Reference: each pulse width in clocks gives floor(width/T) units (max 15);
  // a low strictly longer than GAPU*T closes a word, one strictly longer than
  // ENDU*T (after a closed word) ends the message.
  task automatic run_model(output logic eerr, output logic efin);
    int a, n, c, u;
    a = 0; n = 0; c = 0; eerr = 1'b0; efin = 1'b0;
    exp_q.delete();
    for (int i = 0; i < hw.size(); i++) begin
      if (!efin) begin
        u = hw[i] / T;
        if (u > 15) u = 15;
        if (n < CODE_W) begin
          c = (c * 2 + ((u > DOTM) ? 1 : 0)) % 256;
          n++;
        end else begin
          eerr = 1'b1;
        end
        if (lw[i] > GAPU * T) begin
          exp_q.push_back('{addr: 5'(a), data: 12'(n * 256 + c)});
          n = 0; c = 0;
          if (a == 31) efin = 1'b1;
          else a++;
          if (lw[i] > ENDU * T) efin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic eerr, efin;
    int nw, ns;

    tbl[0] = '{1,  'h100};
    tbl[1] = '{4,  'h100};
    tbl[2] = '{8,  'h100};
    tbl[3] = '{11, 'h100};
    tbl[4] = '{12, 'h101};
    tbl[5] = '{40, 'h101};
    tbl[6] = '{60, 'h101};
    tbl[7] = '{75, 'h101};

    // reset state
    cyc(3);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_fin), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    cyc(2);
    chk("idle_busy", int'(busy), 0);

    // single-pulse classification table
    for (int i = 0; i < 8; i++) begin
      base = q1.size();
      pulse_start();
      drive(1'b0, 3);
      drive(1'b1, tbl[i].width);
      drive(1'b0, ENDU * T + 5);
      chk($sformatf("tbl%0d_cnt", i), q1.size() - base, 1);
      chk_wr($sformatf("tbl%0d", i), base, 0, tbl[i].exp);
      chk($sformatf("tbl%0d_done", i), int'(done_fin), 1);
      chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
    end

    // word with terminating gap and end timing
    base = q1.size();
    pulse_start();
    chk("t1_busy", int'(busy), 1);
    drive(1'b0, 3);
    drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 12);
    drive(1'b0, ENDU * T);
    chk("t1_done_early", int'(done_fin), 0);
    chk("t1_cnt", q1.size() - base, 1);
    chk_wr("t1_w0", base, 0, 'h201);
    drive(1'b0, 5);
    chk("t1_done", int'(done_fin), 1);
    chk("t1_busy_end", int'(busy), 0);

    // two words, start pulse during a HIGH is ignored
    base = q1.size();
    pulse_start();
    drive(1'b0, 3);
    drive(1'b1, 4); drive(1'b0, 4); drive(1'b1, 12); drive(1'b0, 16);
    drive(1'b1, 6);
    start = 1'b1; cyc(1); start = 1'b0;
    drive(1'b1, 5);
    drive(1'b0, ENDU * T + 5);
    chk("t2_cnt", q1.size() - base, 2);
    chk_wr("t2_w0", base, 0, 'h201);
    chk_wr("t2_w1", base + 1, 1, 'h101);
    chk("t2_done", int'(done_fin), 1);

    // start in FIN restarts at address 0
    base = q1.size();
    pulse_start();
    chk("t3_done_clr", int'(done_fin), 0);
    chk("t3_busy", int'(busy), 1);
    drive(1'b0, 3);
    drive(1'b1, 12);
    drive(1'b0, ENDU * T + 5);
    chk("t3_cnt", q1.size() - base, 1);
    chk_wr("t3_w0", base, 0, 'h101);

    // symbol overflow
    base = q1.size();
    pulse_start();
    drive(1'b0, 3);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    drive(1'b0, ENDU * T + 5);
    chk("ovf_cnt", q1.size() - base, 1);
    chk_wr("ovf_w0", base, 0, 'h800);
    chk("ovf_err", int'(err), 1);
    cyc(10);
    chk("ovf_err_hold", int'(err), 1);
    pulse_start();
    chk("ovf_err_clr", int'(err), 0);

    // gap of exactly GAPU units does not split the word
    base = q1.size();
    drive(1'b0, 3);
    drive(1'b1, 4); drive(1'b0, GAPU * T); drive(1'b1, 4);
    drive(1'b0, ENDU * T + 5);
    chk("gapeq_cnt", q1.size() - base, 1);
    chk_wr("gapeq_w0", base, 0, 'h200);

    // reset in the middle of a HIGH
    base = q1.size();
    pulse_start();
    drive(1'b0, 3);
    drive(1'b1, 4); drive(1'b0, 20); drive(1'b1, 4); drive(1'b0, 20);
    drive(1'b1, 6);
    chk("mid_pre_addr", int'(wr_addr), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_wr_en", int'(wr_en), 0);
    chk("mid_wr_addr", int'(wr_addr), 0);
    chk("mid_wr_data", int'(wr_data), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done_fin), 0);
    chk("mid_err", int'(err), 0);
    sig = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    chk("mid_no_write", q1.size() - base, 2);
    base = q1.size();
    pulse_start();
    drive(1'b0, 3);
    drive(1'b1, 12);
    drive(1'b0, ENDU * T + 5);
    chk("mid_after_cnt", q1.size() - base, 1);
    chk_wr("mid_after_w0", base, 0, 'h101);

    // memory full on the 2-bit address instance
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    sig2 = 1'b0; cyc(3);
    for (int i = 0; i < 4; i++) begin
      sig2 = 1'b1; cyc(4);
      sig2 = 1'b0; cyc((i < 3) ? 16 : 20);
    end
    chk("full_cnt", q2.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q2.size()) begin
        chk($sformatf("full_w%0d_addr", i), int'(q2[i].addr), i);
        chk($sformatf("full_w%0d_data", i), int'(q2[i].data), 'h100);
      end
    end
    chk("full_done", int'(done2), 1);
    chk("full_busy", int'(busy2), 0);

    // randomized messages against the reference model
    for (int m = 0; m < 12; m++) begin
      hw.delete();
      lw.delete();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        ns = $urandom_range(1, 10);
        for (int s = 0; s < ns; s++) begin
          hw.push_back($urandom_range(1, 40));
          if (s < ns - 1)      lw.push_back($urandom_range(1, GAPU * T));
          else if (w < nw - 1) lw.push_back($urandom_range(GAPU * T + 2, ENDU * T));
          else                 lw.push_back($urandom_range(ENDU * T + 1, ENDU * T + 12));
        end
      end
      run_model(eerr, efin);
      base = q1.size();
      pulse_start();
      drive(1'b0, 2);
      for (int i = 0; i < hw.size(); i++) begin
        drive(1'b1, hw[i]);
        drive(1'b0, lw[i]);
      end
      drive(1'b0, 4);
      chk($sformatf("rnd%0d_cnt", m), q1.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        chk_wr($sformatf("rnd%0d_w%0d", m, i), base + i, int'(exp_q[i].addr), int'(exp_q[i].data));
      chk($sformatf("rnd%0d_err", m), int'(err), int'(eerr));
      chk($sformatf("rnd%0d_done", m), int'(done_fin), int'(efin));
      chk($sformatf("rnd%0d_busy", m), int'(busy), int'(!efin));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
